miriscv_mem_arbiter: RTL
========================

MIRISCV_MEM_ARBITER -- requirements
Module: miriscv_mem_arbiter

Interface
REQ-001 Parameter OUTST_DEPTH, default 2, max accepted-but-unanswered transactions (power of two, >=1).
REQ-002 clk_i  input  1  core clock; all state updates on rising edge.
REQ-003 arstn_i  input  1  synchronous active-low reset.
REQ-004 instr_req_i / instr_addr_i  input  1 / XLEN  fetch read request, word address.
REQ-005 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-006 instr_rvalid_o / instr_rdata_o  output  1 / XLEN  fetch response.
REQ-007 data_req_i, data_we_i / data_be_i / data_addr_i, data_wdata_i  input  1, 1 / 4 / XLEN, XLEN  LSU request.
REQ-008 data_gnt_o  output  1  LSU request accepted this cycle.
REQ-009 data_rvalid_o / data_rdata_o  output  1 / XLEN  LSU response (reads and writes).
REQ-010 mem_req_o, mem_we_o / mem_be_o / mem_addr_o, mem_wdata_o  output  1, 1 / 4 / XLEN, XLEN  shared memory port.
REQ-011 mem_gnt_i  input  1  memory accepts mem_req_o this cycle.
REQ-012 mem_rvalid_i / mem_rdata_i  input  1 / XLEN  in-order memory response, exactly one per accepted transaction.
REQ-013 resp_err_o  output  1  sticky: response received with no outstanding transaction.

Function
REQ-014 Winner selected combinationally each cycle from asserted requests; mem_* outputs carry winner's fields; mem_we_o=0, mem_be_o=4'hF for fetch.
REQ-015 mem_req_o = (instr_req_i | data_req_i) & ~owner_full; no request passes while owner FIFO full, even if mem_rvalid_i pops same cycle.
REQ-016 <requester>_gnt_o = mem_req_o & mem_gnt_i & (winner == requester); never both grants in one cycle.
REQ-017 Each grant pushes owner ID (0=instr, 1=data) into OUTST_DEPTH-deep owner FIFO.
REQ-018 mem_rvalid_i pops FIFO head; routes to instr_rvalid_o or data_rvalid_o same cycle (zero added latency); both rdata outputs driven from mem_rdata_i unconditionally.
REQ-019 Simultaneous push and pop when not full: both occur, occupancy unchanged.
REQ-020 mem_rvalid_i with empty FIFO: no rvalid forwarded, FIFO unchanged, resp_err_o set.
REQ-021 Read/write pointers wrap modulo OUTST_DEPTH; occupancy counter width clog2(OUTST_DEPTH)+1.
REQ-022 Request held without grant: winner fields stable-driven from current inputs; no internal capture.

Reset
REQ-023 arstn_i low at clock edge: FIFO empty, pointers/occupancy 0, resp_err_o 0, round-robin pointer points at data.
REQ-024 Reset mid-transaction discards outstanding owners; later mem_rvalid_i treated per REQ-020.
REQ-025 During reset all grant and rvalid outputs combinationally track rules above with empty FIFO state after first edge.

Configuration
REQ-026 Macro MIRISCV_ARB_ROUND_ROBIN_EN undefined: fixed priority, data wins over instr whenever both request.
REQ-027 MIRISCV_ARB_ROUND_ROBIN_EN defined: 1-bit last-grant register updated on each grant; on contention requester not granted last wins; single requester always wins.

Verification
REQ-028 Both request, mem_gnt_i=1, macro undefined -> data_gnt_o=1, instr_gnt_o=0 for 3 consecutive cycles; instr granted cycle data_req_i drops.
REQ-029 Same, macro defined -> grants alternate data, instr, data; mem_addr_o alternates matching addresses.
REQ-030 OUTST_DEPTH=2, two fetch grants, no rvalid -> mem_req_o=0 third cycle; one mem_rvalid_i with rdata 0x00000013 -> instr_rvalid_o=1, instr_rdata_o=0x00000013, mem_req_o=1 next cycle.
REQ-031 Grant data write (be=4'b0011) then instr read; two rvalids -> data_rvalid_o first, instr_rvalid_o second, in order.
REQ-032 mem_rvalid_i with FIFO empty -> no rvalid forwarded, resp_err_o=1 until arstn_i low edge clears it.

Source files
------------

// File: rtl/miriscv_mem_arbiter.sv
// Two-requester (fetch/LSU) arbiter onto one in-order memory port, with an owner FIFO routing responses.
// Optional round-robin arbitration is enabled by defining MIRISCV_ARB_ROUND_ROBIN_EN; default is data-over-instr priority.
module miriscv_mem_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned OUTST_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            arstn_i,

    input  logic            instr_req_i,
    input  logic [XLEN-1:0] instr_addr_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    output logic [XLEN-1:0] instr_rdata_o,

    input  logic            data_req_i,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [XLEN-1:0] data_addr_i,
    input  logic [XLEN-1:0] data_wdata_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    output logic [XLEN-1:0] data_rdata_o,

    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            resp_err_o
);

    localparam int unsigned PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUTST_DEPTH) + 1;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    owner_e           owner_q [OUTST_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    owner_e winner;
    logic   full, empty, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(OUTST_DEPTH));
    assign empty = (cnt_q == '0);

`ifdef MIRISCV_ARB_ROUND_ROBIN_EN
    owner_e last_gnt_q, last_gnt_d;

    // On contention the side not granted last wins; reset value lets data win first.
    always_comb begin
        winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
        if (instr_req_i && data_req_i)
            winner = (last_gnt_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    end

    assign last_gnt_d = push ? winner : last_gnt_q;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) last_gnt_q <= OWNER_INSTR;
        else          last_gnt_q <= last_gnt_d;
    end
`else
    always_comb begin
        winner = data_req_i ? OWNER_DATA : OWNER_INSTR;
    end
`endif

    always_comb begin
        mem_req_o   = (instr_req_i | data_req_i) & ~full;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        if (winner == OWNER_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & (winner == OWNER_INSTR);
    assign data_gnt_o  = push & (winner == OWNER_DATA);

    // A response with nothing outstanding is flagged and otherwise dropped.
    assign pop            = mem_rvalid_i & ~empty;
    assign instr_rvalid_o = pop & (owner_q[rptr_q] == OWNER_INSTR);
    assign data_rvalid_o  = pop & (owner_q[rptr_q] == OWNER_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign resp_err_o     = err_q;

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        err_d  = err_q | (mem_rvalid_i & empty);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // NOTE: owner storage is not reset; entries are only read while the occupancy counter says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) owner_q[wptr_q] <= winner;
    end

endmodule
